// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute/commit sequencer with fetch timeout, halt control and field decode
// Ports:
//   CLK, RESETN (async, active-high)
//   DIN, MEM_RDY     instruction word and its valid strobe during fetch
//   STALL            holds the execute phase
//   HALT_REQ, RESUME halt level and resume pulse
//   CCZ/CCC/CCV/CCP  condition flags sampled in decode
//   FETCH..HALTED    one-hot phase indicators (all low in reset)
//   GPX/OPX/INCX/SKIPX/CCX/ARGX/ARGA/ARGB  fields decoded from the instruction register
//   DO_JUMP, ADDRX, WRITEN (active-low), BUS_ERR
module instruction_sequencer #(
  parameter int IW  = 16,
  parameter int RW  = 4,
  parameter int TMO = 15
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic [IW-1:0] DIN,
  input  logic          MEM_RDY,
  input  logic          STALL,
  input  logic          HALT_REQ,
  input  logic          RESUME,
  input  logic          CCZ,
  input  logic          CCC,
  input  logic          CCV,
  input  logic          CCP,
  output logic          FETCH,
  output logic          DECODE,
  output logic          EXECUTE,
  output logic          COMMIT,
  output logic          HALTED,
  output logic [1:0]    GPX,
  output logic [3:0]    OPX,
  output logic [1:0]    INCX,
  output logic [1:0]    SKIPX,
  output logic [1:0]    CCX,
  output logic [1:0]    ARGX,
  output logic [RW-1:0] ARGA,
  output logic [RW-1:0] ARGB,
  output logic          DO_JUMP,
  output logic [1:0]    ADDRX,
  output logic          WRITEN,
  output logic          BUS_ERR
);
  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_COMMIT, S_HALT} state_t;
  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic [7:0]    r_wcnt;
  logic          r_do_jump;
  logic          r_bus_err;
  logic [1:0]    w_g;
  logic [1:0]    w_hi;
  logic [1:0]    w_lo;
  logic [3:0]    w_flags;
  logic          w_jump;
  logic          w_halt_instr;
  logic          w_unused;
  assign w_g  = r_ir[IW-1:IW-2];
  assign w_hi = r_ir[IW-3:IW-4];
  assign w_lo = r_ir[2*RW+1:2*RW];
  // some IR bits carry no field for wider builds
  assign w_unused = ^r_ir;
  assign GPX   = w_g;
  assign ARGA  = r_ir[2*RW-1:RW];
  assign ARGB  = r_ir[RW-1:0];
  assign OPX   = w_g == 2'd0 ? {1'b0, r_ir[IW-3:IW-5]} :
                 w_g == 2'd3 ? r_ir[IW-3:IW-6] : {2'b00, r_ir[IW-5:IW-6]};
  assign INCX  = w_g == 2'd1 ? w_hi : 2'd0;
  assign SKIPX = w_g == 2'd2 ? w_hi : 2'd0;
  assign CCX   = w_g == 2'd2 ? w_lo : 2'd0;
  assign ARGX  = w_g[0] ? w_lo : 2'd0;
  // flag selected by CCX: 0 C, 1 Z, 2 P, 3 V
  assign w_flags = {CCV, CCP, CCZ, CCC};
  // unconditional skip when SKIPX[1]=0, otherwise flag must equal SKIPX[0]
  assign w_jump       = w_g == 2'd2 && (!SKIPX[1] || w_flags[CCX] == SKIPX[0]);
  assign w_halt_instr = w_g == 2'd0 && r_ir[IW-3:IW-5] == 3'b111;
  assign FETCH   = r_state == S_FETCH;
  assign DECODE  = r_state == S_DECODE;
  assign EXECUTE = r_state == S_EXEC;
  assign COMMIT  = r_state == S_COMMIT;
  assign HALTED  = r_state == S_HALT;
  assign ADDRX   = FETCH ? 2'd1 : 2'd0;
  assign WRITEN  = !COMMIT;
  assign DO_JUMP = r_do_jump;
  assign BUS_ERR = r_bus_err;
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_state   <= S_RST;
      r_ir      <= '0;
      r_wcnt    <= '0;
      r_do_jump <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      // counter only runs while fetching, so every fetch entry starts from zero
      if (r_state != S_FETCH) r_wcnt <= '0;
      case (r_state)
        S_RST:    r_state <= S_FETCH;
        S_FETCH:
          if (MEM_RDY) begin
            r_ir    <= DIN;
            r_state <= S_DECODE;
          end else if (r_wcnt == 8'(TMO)) begin
            r_bus_err <= 1'b1;
            r_state   <= S_HALT;
          end else r_wcnt <= r_wcnt + 8'd1;
        S_DECODE: begin
          r_do_jump <= w_jump;
          r_state   <= S_EXEC;
        end
        S_EXEC:   if (!STALL) r_state <= S_COMMIT;
        S_COMMIT: r_state <= (HALT_REQ || w_halt_instr) ? S_HALT : S_FETCH;
        S_HALT:   if (RESUME && !HALT_REQ) r_state <= S_FETCH;
        default:  r_state <= S_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed plus randomized checks of instruction_sequencer against a transaction-level model
module tb_instruction_sequencer;
  localparam int TMO = 15;
  localparam logic [4:0] P_0 = 5'b00000, P_F = 5'b10000, P_D = 5'b01000,
                         P_E = 5'b00100, P_C = 5'b00010, P_H = 5'b00001;
  logic        CLK = 0, RESETN = 1;
  logic [15:0] DIN = 0;
  logic [19:0] DIN2 = 0;
  logic        MEM_RDY = 0, STALL = 0, HALT_REQ = 0, RESUME = 0;
  logic        CCZ = 0, CCC = 0, CCV = 0, CCP = 0;
  logic        FETCH, DECODE, EXECUTE, COMMIT, HALTED, DO_JUMP, WRITEN, BUS_ERR;
  logic [1:0]  GPX, INCX, SKIPX, CCX, ARGX, ADDRX;
  logic [3:0]  OPX, ARGA, ARGB;
  logic        FETCH2, DECODE2, EXECUTE2, COMMIT2, HALTED2, DO_JUMP2, WRITEN2, BUS_ERR2;
  logic [1:0]  GPX2, INCX2, SKIPX2, CCX2, ARGX2, ADDRX2;
  logic [3:0]  OPX2;
  logic [4:0]  ARGA2, ARGB2;
  int n_cmp = 0, n_err = 0;

  instruction_sequencer #(.IW(16), .RW(4), .TMO(TMO)) dut (
    .CLK(CLK), .RESETN(RESETN), .DIN(DIN), .MEM_RDY(MEM_RDY), .STALL(STALL),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME), .CCZ(CCZ), .CCC(CCC), .CCV(CCV), .CCP(CCP),
    .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT), .HALTED(HALTED),
    .GPX(GPX), .OPX(OPX), .INCX(INCX), .SKIPX(SKIPX), .CCX(CCX), .ARGX(ARGX),
    .ARGA(ARGA), .ARGB(ARGB), .DO_JUMP(DO_JUMP), .ADDRX(ADDRX), .WRITEN(WRITEN), .BUS_ERR(BUS_ERR));

  instruction_sequencer #(.IW(20), .RW(5), .TMO(TMO)) dut2 (
    .CLK(CLK), .RESETN(RESETN), .DIN(DIN2), .MEM_RDY(MEM_RDY), .STALL(STALL),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME), .CCZ(CCZ), .CCC(CCC), .CCV(CCV), .CCP(CCP),
    .FETCH(FETCH2), .DECODE(DECODE2), .EXECUTE(EXECUTE2), .COMMIT(COMMIT2), .HALTED(HALTED2),
    .GPX(GPX2), .OPX(OPX2), .INCX(INCX2), .SKIPX(SKIPX2), .CCX(CCX2), .ARGX(ARGX2),
    .ARGA(ARGA2), .ARGB(ARGB2), .DO_JUMP(DO_JUMP2), .ADDRX(ADDRX2), .WRITEN(WRITEN2), .BUS_ERR(BUS_ERR2));

  always #5 CLK = ~CLK;

  function automatic int fld(int d, int lo, int n);
    return (d >> lo) & ((1 << n) - 1);
  endfunction

  // fl = {C, Z, P, V}
  function automatic bit jump_of(logic [15:0] d, logic [3:0] fl);
    int g = fld(d, 14, 2);
    int sk = fld(d, 12, 2);
    int cc = fld(d, 8, 2);
    bit f;
    if (g != 2) return 0;
    if (sk < 2) return 1;
    f = fl[3 - cc];
    return sk == 3 ? f : !f;
  endfunction

  function automatic bit halts(logic [15:0] d);
    return fld(d, 14, 2) == 0 && fld(d, 11, 3) == 7;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] ph, input logic be);
    chk("phase", {FETCH, DECODE, EXECUTE, COMMIT, HALTED}, ph);
    chk("writen", WRITEN, ph != P_C);
    chk("addrx", ADDRX, ph == P_F ? 1 : 0);
    chk("bus_err", BUS_ERR, be);
    @(posedge CLK); #1;
  endtask

  task automatic chk_fields(input logic [15:0] d);
    int g = fld(d, 14, 2);
    chk("gpx", GPX, g);
    chk("opx", OPX, g == 0 ? fld(d, 11, 3) : g == 3 ? fld(d, 10, 4) : fld(d, 10, 2));
    chk("incx", INCX, g == 1 ? fld(d, 12, 2) : 0);
    chk("skipx", SKIPX, g == 2 ? fld(d, 12, 2) : 0);
    chk("ccx", CCX, g == 2 ? fld(d, 8, 2) : 0);
    chk("argx", ARGX, (g == 1 || g == 3) ? fld(d, 8, 2) : 0);
    chk("arga", ARGA, fld(d, 4, 4));
    chk("argb", ARGB, fld(d, 0, 4));
  endtask

  // starts and ends with the current cycle in FETCH, 1 time unit after the edge
  task automatic run_instr(input logic [15:0] d, input int w, input int s, input bit hreq, input logic [3:0] fl);
    bit h = hreq || halts(d);
    bit j = jump_of(d, fl);
    for (int k = 0; k <= w; k++) begin
      MEM_RDY = (k == w);
      DIN = (k == w) ? d : 16'($urandom);
      cyc(P_F, 0);
    end
    MEM_RDY = 0;
    DIN = 16'($urandom);
    {CCC, CCZ, CCP, CCV} = fl;
    cyc(P_D, 0);
    chk_fields(d);
    chk("do_jump", DO_JUMP, j);
    for (int k = 0; k <= s; k++) begin
      STALL = (k < s);
      {CCC, CCZ, CCP, CCV} = 4'($urandom);
      RESUME = 1'($urandom_range(0, 1));
      cyc(P_E, 0);
    end
    STALL = 0;
    RESUME = 0;
    HALT_REQ = hreq;
    cyc(P_C, 0);
    chk("do_jump_hold", DO_JUMP, j);
    chk_fields(d);
    HALT_REQ = 0;
    if (h) begin
      HALT_REQ = 1;
      RESUME = 1;
      cyc(P_H, 0);
      HALT_REQ = 0;
      cyc(P_H, 0);
      RESUME = 0;
    end
  endtask

  initial begin
    logic [19:0] d2;
    logic [15:0] d;
    #2;
    chk("rst_phase", {FETCH, DECODE, EXECUTE, COMMIT, HALTED}, P_0);
    chk("rst_writen", WRITEN, 1);
    chk("rst_addrx", ADDRX, 0);
    chk("rst_bus_err", BUS_ERR, 0);
    chk("rst_do_jump", DO_JUMP, 0);
    chk_fields(16'h0000);
    @(negedge CLK);
    RESETN = 0;
    #1;
    chk("rst_wait_phase", {FETCH, DECODE, EXECUTE, COMMIT, HALTED}, P_0);
    @(posedge CLK); #1;
    d2 = {2'b11, 18'($urandom)};
    DIN2 = d2;
    run_instr(16'hC512, 0, 0, 0, 4'($urandom));
    chk("w20_gpx", GPX2, 3);
    chk("w20_opx", OPX2, fld(d2, 14, 4));
    chk("w20_argx", ARGX2, fld(d2, 10, 2));
    chk("w20_arga", ARGA2, fld(d2, 5, 5));
    chk("w20_argb", ARGB2, fld(d2, 0, 5));
    d2 = {2'b01, 18'($urandom)};
    DIN2 = d2;
    run_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 3, 0, 0, 4'($urandom));
    chk("w20g1_gpx", GPX2, 1);
    chk("w20g1_incx", INCX2, fld(d2, 16, 2));
    chk("w20g1_opx", OPX2, fld(d2, 14, 2));
    chk("w20g1_argx", ARGX2, fld(d2, 10, 2));
    run_instr(16'hE3C7, TMO, 1, 0, 4'($urandom));
    MEM_RDY = 0;
    for (int k = 0; k <= TMO; k++) cyc(P_F, 0);
    cyc(P_H, 1);
    chk_fields(16'hE3C7);
    cyc(P_H, 0);
    RESUME = 1;
    cyc(P_H, 0);
    RESUME = 0;
    run_instr(16'hA1F0, 0, 0, 0, 4'b0000);
    run_instr(16'hA1F0, 1, 0, 0, 4'b0100);
    run_instr(16'h81F0, 0, 0, 0, 4'b1111);
    run_instr(16'hC512, 0, 5, 1, 4'($urandom));
    run_instr(16'h3800, 0, 0, 0, 4'($urandom));
    MEM_RDY = 1;
    DIN = 16'h81F0;
    cyc(P_F, 0);
    MEM_RDY = 0;
    cyc(P_D, 0);
    STALL = 1;
    cyc(P_E, 0);
    #2;
    RESETN = 1;
    #1;
    chk("mid_rst_phase", {FETCH, DECODE, EXECUTE, COMMIT, HALTED}, P_0);
    chk("mid_rst_writen", WRITEN, 1);
    chk("mid_rst_addrx", ADDRX, 0);
    chk("mid_rst_bus_err", BUS_ERR, 0);
    chk("mid_rst_do_jump", DO_JUMP, 0);
    chk_fields(16'h0000);
    @(posedge CLK); #1;
    chk("mid_rst_hold_phase", {FETCH, DECODE, EXECUTE, COMMIT, HALTED}, P_0);
    chk("mid_rst_hold_writen", WRITEN, 1);
    @(negedge CLK);
    RESETN = 0;
    STALL = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = 16'h3800 | (d & 16'h07FF);
      run_instr(d, $urandom_range(0, 4) == 0 ? TMO : $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4) == 0, 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
